seq1001_tx: RTL and testbench



---
 rtl/seq_tx_pkg.sv | 9 +
 rtl/bit_tick_gen.sv | 26 ++
 rtl/seq1001_tx.sv | 111 +++++++++++
 tb/tb_seq1001_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the 1001 sync-word serial transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} tx_state_t;

    localparam int                       SYNC_LEN_DEF = 4;
    localparam logic [SYNC_LEN_DEF-1:0]  SYNC_PAT_DEF = 4'b1001;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: tick is high in the last cycle of every BIT_DIV-cycle period.
module bit_tick_gen #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int               DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] TERM  = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/seq1001_tx.sv
// Serial framer: sends SYNC_PAT, then the latched payload MSB first, then one 0 guard bit.
module seq1001_tx
    import seq_tx_pkg::*;
#(
    parameter int                  SYNC_LEN = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int                  DATA_W   = 8,
    parameter int                  BIT_DIV  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    localparam int               MAX_LEN   = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_SYNC = IDX_W'(SYNC_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);

    tx_state_t           state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [DATA_W-1:0]   sr, sr_n;
    logic [SYNC_LEN-1:0] sync_sh;
    logic                dout_n;
    logic                tick;
    logic                accept;

    assign accept = (state == IDLE) && tx_valid;

    bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            sr    <= '0;
            dout  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            sr    <= sr_n;
            dout  <= dout_n;
        end
    end

    // dout is registered from the next-state view so the line changes on the same edge as the state.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        sr_n    = sr;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = SYNC;
                    idx_n   = '0;
                    sr_n    = tx_data;
                end
            end
            SYNC: begin
                if (tick) begin
                    if (idx == LAST_SYNC) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sr_n = sr << 1;
                    if (idx == LAST_DATA) begin
                        state_n = GAP;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        sync_sh = SYNC_PAT << idx_n;
        dout_n  = 1'b0;
        unique case (state_n)
            SYNC:    dout_n = sync_sh[SYNC_LEN-1];
            DATA:    dout_n = sr_n[DATA_W-1];
            default: dout_n = 1'b0;
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == GAP) && tick;

endmodule

// File: tb/tb_seq1001_tx.sv
// Randomized bench for seq1001_tx (BIT_DIV=1 and BIT_DIV=3) against a frame-schedule reference model.
module tb_seq1001_tx;

    localparam int FBITS = 13;
    localparam int DIV3  = 3;

    logic       clk;
    logic       reset;
    logic       v0, v3;
    logic [7:0] d0, d3;
    logic       rdy0, rdy3, dout0, dout3, busy0, busy3, done0, done3;

    seq1001_tx dut0 (
        .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
        .tx_ready(rdy0), .dout(dout0), .busy(busy0), .done(done0)
    );

    seq1001_tx #(.BIT_DIV(DIV3)) dut3 (
        .clk(clk), .reset(reset), .tx_data(d3), .tx_valid(v3),
        .tx_ready(rdy3), .dout(dout3), .busy(busy3), .done(done3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ph = cycles since accept (-1 when idle), lat = payload latched at accept.
    int         ph [2];
    logic [7:0] lat [2];
    int         acc_cnt [2];
    int         acc_cyc [2];
    int         bz_cnt [2];
    int         dn_cnt [2];
    int         cyc = 0;

    logic [3:0] hist;
    int         since = 100;
    int         det_cnt = 0;
    int         det_ph = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : DIV3;
    endfunction

    function automatic logic fbit(input logic [7:0] d, input int j);
        logic [3:0] s;
        s = 4'b1001;
        if (j < 4)       return s[3-j];
        else if (j < 12) return d[11-j];
        else             return 1'b0;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                logic       vk;
                logic [7:0] dk;
                vk = (k == 0) ? v0 : v3;
                dk = (k == 0) ? d0 : d3;
                if (reset) begin
                    ph[k] = -1;
                end else if (ph[k] < 0) begin
                    if (vk) begin
                        ph[k]      = 0;
                        lat[k]     = dk;
                        acc_cnt[k] = acc_cnt[k] + 1;
                        acc_cyc[k] = cyc;
                    end
                end else begin
                    ph[k] = ph[k] + 1;
                    if (ph[k] >= FBITS * div_of(k)) ph[k] = -1;
                end
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic eb, ed, edn, gb, gd, gdn, gr;
                eb  = (ph[k] >= 0);
                ed  = eb ? fbit(lat[k], ph[k] / div_of(k)) : 1'b0;
                edn = (ph[k] == FBITS * div_of(k) - 1);
                gb  = (k == 0) ? busy0 : busy3;
                gd  = (k == 0) ? dout0 : dout3;
                gdn = (k == 0) ? done0 : done3;
                gr  = (k == 0) ? rdy0  : rdy3;
                check_eq($sformatf("dout%0d@%0d", k, cyc), 32'(gd), 32'(ed));
                check_eq($sformatf("busy%0d@%0d", k, cyc), 32'(gb), 32'(eb));
                check_eq($sformatf("ready%0d@%0d", k, cyc), 32'(gr), 32'(!eb));
                check_eq($sformatf("done%0d@%0d", k, cyc), 32'(gdn), 32'(edn));
                bz_cnt[k] = bz_cnt[k] + int'(gb);
                dn_cnt[k] = dn_cnt[k] + int'(gdn);
            end
            // Non-overlapping 1001 detector on the dut0 line.
            hist  = {hist[2:0], dout0};
            since = since + 1;
            if (hist == 4'b1001 && since >= 4) begin
                det_cnt = det_cnt + 1;
                det_ph  = ph[0];
                since   = 0;
            end
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            bz_cnt[k] = 0;
            dn_cnt[k] = 0;
        end
    endtask

    initial begin
        logic [12:0] seq;
        logic [12:0] exp_a5;
        int          n1, a1, b;

        reset = 1'b1; v0 = 1'b0; v3 = 1'b0; d0 = '0; d3 = '0; hist = '0;
        for (int k = 0; k < 2; k++) begin
            ph[k] = -1; lat[k] = '0; acc_cnt[k] = 0; acc_cyc[k] = 0;
        end
        clear_counts();
        step(2);
        check_eq("reset_ready", 32'(rdy0), 32'd1);
        check_eq("reset_dout", 32'(dout0), 32'd0);
        reset = 1'b0;
        step(2);

        // Single 8'hA5 frame
        clear_counts();
        exp_a5 = 13'b1001101001010;
        v0 = 1'b1; d0 = 8'hA5;
        step(1);
        v0 = 1'b0; d0 = 8'($urandom);
        seq = '0;
        for (int i = 0; i < FBITS; i++) begin
            seq = {seq[11:0], dout0};
            step(1);
        end
        check_eq("a5_seq", 32'(seq), 32'(exp_a5));
        check_eq("a5_busy_cycles", 32'(bz_cnt[0]), 32'd13);
        check_eq("a5_done_pulses", 32'(dn_cnt[0]), 32'd1);
        check_eq("a5_ready_after", 32'(rdy0), 32'd1);
        step(2);

        // BIT_DIV=3, 8'h0F
        clear_counts();
        v3 = 1'b1; d3 = 8'h0F;
        step(1);
        v3 = 1'b0; d3 = 8'($urandom);
        step(42);
        check_eq("div3_busy_cycles", 32'(bz_cnt[1]), 32'd39);
        check_eq("div3_done_pulses", 32'(dn_cnt[1]), 32'd1);

        // Back-to-back with tx_valid held
        v0 = 1'b1; d0 = 8'h81;
        step(1);
        n1 = acc_cnt[0];
        a1 = acc_cyc[0];
        d0 = 8'h7E;
        for (b = 0; b < 40 && acc_cnt[0] == n1; b++) step(1);
        v0 = 1'b0;
        check_eq("b2b_second_accept", 32'(acc_cnt[0]), 32'(n1 + 1));
        check_eq("b2b_period", 32'(acc_cyc[0] - a1), 32'd14);
        step(16);

        // tx_valid / tx_data toggled while busy
        v0 = 1'b1; d0 = 8'($urandom);
        step(1);
        for (int i = 0; i < 10; i++) begin
            v0 = 1'($urandom);
            d0 = 8'($urandom);
            step(1);
        end
        v0 = 1'b0;
        step(20);

        // Reset during DATA bit 3 of an 8'hFF frame
        v0 = 1'b1; d0 = 8'hFF;
        step(1);
        v0 = 1'b0;
        for (b = 0; b < 20 && ph[0] != 7; b++) step(1);
        check_eq("rst_mid_reached_bit3", 32'(ph[0]), 32'd7);
        clear_counts();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("rst_mid_dout", 32'(dout0), 32'd0);
        check_eq("rst_mid_busy", 32'(busy0), 32'd0);
        check_eq("rst_mid_ready", 32'(rdy0), 32'd1);
        step(4);
        check_eq("rst_mid_no_done", 32'(dn_cnt[0]), 32'd0);
        v0 = 1'b1; d0 = 8'($urandom);
        step(1);
        v0 = 1'b0;
        step(14);
        check_eq("rst_fresh_done", 32'(dn_cnt[0]), 32'd1);

        // Loopback into the 1001 detector
        for (int p = 0; p < 2; p++) begin
            det_cnt = 0;
            det_ph  = -1;
            v0 = 1'b1; d0 = (p == 0) ? 8'h00 : 8'hFF;
            step(1);
            v0 = 1'b0;
            step(16);
            check_eq($sformatf("loop%0d_det_count", p), 32'(det_cnt), 32'd1);
            check_eq($sformatf("loop%0d_det_pos", p), 32'(det_ph), 32'd3);
        end

        // Random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            v0 = ($urandom_range(0, 3) == 0);
            d0 = 8'($urandom);
            v3 = ($urandom_range(0, 5) == 0);
            d3 = 8'($urandom);
            step(1);
        end
        v0 = 1'b0; v3 = 1'b0;
        step(45);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
